bk_operand_recover: RTL and testbench

Sequential inverse of the 12-bit Brent-Kung adder. Takes a 13-bit sum word (adder output format) and operand A, and recovers operand B = SUM − A, DIGIT bits per cycle. Emits the reconstructed interleaved 24-bit adder input word, so a checker can round-trip adder results. Sits downstream of the adder in the self-check datapath, behind valid/ready handshakes on both sides.

---
 rtl/brent_kung_pkg.sv | 19 +
 rtl/bk_operand_recover_if.sv | 22 ++
 rtl/bk_digit_sub.sv | 12 +
 rtl/bk_operand_recover.sv | 80 ++++++++
 tb/tb_bk_operand_recover.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brent_kung_pkg.sv
// brent_kung_pkg: shared constants, FSM state type and the A/B interleave helper
// for the Brent-Kung adder and its operand-recovery checker.
package brent_kung_pkg;
    localparam int W = 12;
    localparam int DIGIT = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Adder input format: even bits carry A, odd bits carry B.
    function automatic logic [2*W-1:0] pack_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            p[2*i]   = a[i];
            p[2*i+1] = b[i];
        end
        return p;
    endfunction
endpackage

// File: rtl/bk_operand_recover_if.sv
// bk_operand_recover_if: input and output valid/ready channels of the operand recovery block.
interface bk_operand_recover_if;
    import brent_kung_pkg::*;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W:0]     sum_i;
    logic [W-1:0]   a_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [2*W-1:0] pair_o;
    logic [W-1:0]   b_o;
    logic           range_err_o;

    modport master (
        output in_valid_i, sum_i, a_i, out_ready_i,
        input  in_ready_o, out_valid_o, pair_o, b_o, range_err_o
    );
    modport slave (
        input  in_valid_i, sum_i, a_i, out_ready_i,
        output in_ready_o, out_valid_o, pair_o, b_o, range_err_o
    );
endinterface

// File: rtl/bk_digit_sub.sv
// bk_digit_sub: combinational DIGIT-bit subtract-with-borrow cell.
module bk_digit_sub #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);
    assign {bout, d} = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
endmodule

// File: rtl/bk_operand_recover.sv
// bk_operand_recover: recovers B = SUM - A one digit per cycle and re-interleaves {A,B}.
// BK_RANGE_CHECK_EN enables the range_err_o check; undefined ties it to 0.
module bk_operand_recover
    import brent_kung_pkg::*;
(
    input logic clk,
    input logic rst,
    bk_operand_recover_if.slave bus
);
    localparam int NDIG = W / DIGIT;
    localparam int CW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t         state, state_n;
    logic [W-1:0]   sum_q, a_q, b_q;
    logic [CW-1:0]  k;
    logic           borrow;
    logic [DIGIT-1:0] d;
    logic           bout;
`ifdef BK_RANGE_CHECK_EN
    logic           cout_q;
`endif

    // One subtract cell, walked across the operands by the digit counter.
    bk_digit_sub #(.DIGIT(DIGIT)) u_sub (
        .x    (sum_q[k*DIGIT +: DIGIT]),
        .y    (a_q[k*DIGIT +: DIGIT]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.range_err_o = 1'b0;
        state_n = (state == IDLE && bus.in_valid_i) ? RUN :
                  (state == RUN  && k == LAST)      ? DONE :
                  (state == DONE && bus.out_ready_i) ? IDLE : state;
        bus.in_ready_o  = state == IDLE;
        bus.out_valid_o = state == DONE;
`ifdef BK_RANGE_CHECK_EN
        // Result fits in W bits only when the carry-out cancels the final borrow.
        bus.range_err_o = (state == DONE) & (cout_q ^ borrow);
`endif
        bus.b_o    = b_q;
        bus.pair_o = pack_pair(a_q, b_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            k      <= '0;
            borrow <= 1'b0;
`ifdef BK_RANGE_CHECK_EN
            cout_q <= 1'b0;
`endif
        end else if (state == IDLE && bus.in_valid_i) begin
            sum_q  <= bus.sum_i[W-1:0];
            a_q    <= bus.a_i;
            k      <= '0;
            borrow <= 1'b0;
`ifdef BK_RANGE_CHECK_EN
            cout_q <= bus.sum_i[W];
`endif
        end else if (state == RUN) begin
            b_q[k*DIGIT +: DIGIT] <= d;
            borrow <= bout;
            k      <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_bk_operand_recover.sv
// tb_bk_operand_recover: scoreboard bench for bk_operand_recover; expectations are
// pushed at accept and popped when the result is presented.
module tb_bk_operand_recover;
    typedef struct {
        logic [11:0] b;
        logic [23:0] pair;
        logic        err;
    } exp_t;

    localparam bit CHK =
`ifdef BK_RANGE_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bk_operand_recover_if bus ();
    bk_operand_recover dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic exp_t mk(input logic [11:0] b, input logic [11:0] a, input bit err);
        exp_t e;
        e.b = b;
        e.err = err & CHK;
        e.pair = '0;
        for (int i = 0; i < 12; i++) begin
            e.pair[2*i]   = a[i];
            e.pair[2*i+1] = b[i];
        end
        return e;
    endfunction

    task automatic run_op(input logic [12:0] s, input logic [11:0] a, input exp_t e, input int hold);
        int n;
        exp_t x;
        logic [11:0] b0;
        logic [23:0] p0;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait in_ready=%b want 1", bus.in_ready_o);
            return;
        end
        bus.sum_i = s;
        bus.a_i = a;
        bus.in_valid_i = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        total++;
        if (bus.in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready in_ready=%b want 0", bus.in_ready_o);
        end
        n = 0;
        while (bus.out_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL latency got=%0d want=6", n);
        end
        if (bus.out_valid_o !== 1'b1) begin
            sb.delete();
            return;
        end
        x = sb.pop_front();
        total++;
        if (bus.b_o !== x.b) begin
            bad++;
            $display("FAIL b_o s=%h a=%h got=%h want=%h", s, a, bus.b_o, x.b);
        end
        total++;
        if (bus.pair_o !== x.pair) begin
            bad++;
            $display("FAIL pair_o s=%h a=%h got=%h want=%h", s, a, bus.pair_o, x.pair);
        end
        total++;
        if (bus.range_err_o !== x.err) begin
            bad++;
            $display("FAIL range_err s=%h a=%h got=%b want=%b", s, a, bus.range_err_o, x.err);
        end
        b0 = bus.b_o;
        p0 = bus.pair_o;
        repeat (hold) begin
            @(negedge clk);
            total++;
            if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.b_o !== b0 || bus.pair_o !== p0) begin
                bad++;
                $display("FAIL hold_stable valid=%b ready=%b b=%h pair=%h want 1 0 %h %h",
                         bus.out_valid_o, bus.in_ready_o, bus.b_o, bus.pair_o, b0, p0);
            end
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        total++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL release ready=%b valid=%b want 1 0", bus.in_ready_o, bus.out_valid_o);
        end
    endtask

    task automatic test_reset;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.sum_i = '0;
        bus.a_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.b_o !== 12'h0 ||
            bus.pair_o !== 24'h0 || bus.range_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state ready=%b valid=%b b=%h pair=%h err=%b want 1 0 0 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.b_o, bus.pair_o, bus.range_err_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_op(13'h0FFF, 12'h800, mk(12'h7FF, 12'h800, 1'b0), 0);
    endtask

    task automatic test_carry;
        run_op(13'h1000, 12'hFFF, mk(12'h001, 12'hFFF, 1'b0), 0);
        run_op(13'h1FFE, 12'hFFF, mk(12'hFFF, 12'hFFF, 1'b0), 0);
    endtask

    task automatic test_range;
        run_op(13'h0005, 12'h006, mk(12'hFFF, 12'h006, 1'b1), 0);
        run_op(13'h1FFF, 12'h000, mk(12'hFFF, 12'h000, 1'b1), 0);
    endtask

    task automatic test_backpressure;
        run_op(13'h0ABC, 12'h123, mk(12'h999, 12'h123, 1'b0), 10);
    endtask

    task automatic test_back_to_back;
        localparam int N = 5;
        logic [11:0] av[N], bv[N];
        int acc[N];
        int idx, outs;
        exp_t x;
        for (int i = 0; i < N; i++) begin
            av[i] = 12'($urandom_range(0, 4095));
            bv[i] = 12'($urandom_range(0, 4095));
        end
        idx = 0;
        outs = 0;
        bus.out_ready_i = 1'b1;
        for (int t = 0; t < N * 8 + 30 && outs < N; t++) begin
            @(negedge clk);
            if (bus.out_valid_o === 1'b1) begin
                outs++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected b=%h", bus.b_o);
                end else begin
                    x = sb.pop_front();
                    if (bus.b_o !== x.b || bus.pair_o !== x.pair || bus.range_err_o !== x.err) begin
                        bad++;
                        $display("FAIL b2b_result b=%h pair=%h err=%b want %h %h %b",
                                 bus.b_o, bus.pair_o, bus.range_err_o, x.b, x.pair, x.err);
                    end
                end
            end
            if (idx < N) begin
                bus.in_valid_i = 1'b1;
                bus.a_i = av[idx];
                bus.sum_i = {1'b0, av[idx]} + {1'b0, bv[idx]};
                if (bus.in_ready_o === 1'b1) begin
                    sb.push_back(mk(bv[idx], av[idx], 1'b0));
                    acc[idx] = cyc;
                    idx++;
                end
            end else begin
                bus.in_valid_i = 1'b0;
            end
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        total++;
        if (outs !== N || idx !== N) begin
            bad++;
            $display("FAIL b2b_count outs=%0d accepts=%0d want %0d", outs, idx, N);
        end
        for (int i = 1; i < idx; i++) begin
            total++;
            if (acc[i] - acc[i-1] !== 8) begin
                bad++;
                $display("FAIL b2b_interval op=%0d got=%0d want=8", i, acc[i] - acc[i-1]);
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.sum_i = 13'h0FFF;
        bus.a_i = 12'h800;
        bus.in_valid_i = 1'b1;
        sb.push_back(mk(12'h7FF, 12'h800, 1'b0));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.b_o !== 12'h0 || bus.pair_o !== 24'h0) begin
            bad++;
            $display("FAIL reset_abort valid=%b ready=%b b=%h pair=%h want 0 1 0 0",
                     bus.out_valid_o, bus.in_ready_o, bus.b_o, bus.pair_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL reset_quiet bad_cycles=%0d want 0", n);
        end
        run_op(13'h0003, 12'h001, mk(12'h002, 12'h001, 1'b0), 0);
    endtask

    task automatic test_random;
        logic [11:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            run_op({1'b0, a} + {1'b0, b}, a, mk(b, a, 1'b0), (i % 50 == 0) ? 2 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
